// File: rtl/mdio_slave_if.sv
// Wishbone classic bus between the MDIO front end and the register file.
interface mdio_slave_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [4:0]  addr;
    logic [15:0] data_write;
    logic        ack;
    logic        err;
    logic [15:0] data_read;

    modport master (
        output cyc, stb, we, addr, data_write,
        input  ack, err, data_read
    );

    modport slave (
        input  cyc, stb, we, addr, data_write,
        output ack, err, data_read
    );
endinterface

// File: rtl/mdio_slave.sv
// Clause 22 MDIO frame receiver: decodes frames on mdc/mdi, issues one Wishbone
// cycle per matched frame and shifts read data back out on mdo.
module mdio_slave #(
    parameter logic [4:0]  PHYAD        = 5'd0,
    parameter int unsigned PREAMBLE_LEN = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mdc,
    input  logic mdi,
    output logic mdo,
    output logic mdo_en,
    mdio_slave_if.master wb
);

    localparam logic [5:0] PRE_MAX = 6'(PREAMBLE_LEN);

    typedef enum logic [2:0] {S_PRE, S_ST, S_OP, S_PHY, S_REG, S_TA, S_DATA} state_t;

    state_t      state, state_nxt;
    logic        mdc_s1, mdc_s2, mdc_d, mdi_s1, mdi_s2;
    logic        bit_ev, rx_bit;
    logic [5:0]  ones_cnt;
    logic [3:0]  bit_cnt;
    logic        op_hi, rd_frame;
    logic [4:0]  phy_r, reg_r;
    logic [14:0] rx_sr;
    logic [15:0] tx_sr;
    logic        cyc_q, we_q;
    logic [4:0]  addr_q;
    logic [15:0] wdata_q;
    logic        rd_live, rd_ok, cap;

    assign bit_ev = mdc_s2 & ~mdc_d;
    assign rx_bit = mdi_s2;

    assign wb.cyc        = cyc_q;
    assign wb.stb        = cyc_q;
    assign wb.we         = we_q;
    assign wb.addr       = addr_q;
    assign wb.data_write = wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdc_s1 <= 1'b0;
            mdc_s2 <= 1'b0;
            mdc_d  <= 1'b0;
            mdi_s1 <= 1'b0;
            mdi_s2 <= 1'b0;
        end else begin
            mdc_s1 <= mdc;
            mdc_s2 <= mdc_s1;
            mdc_d  <= mdc_s2;
            mdi_s1 <= mdi;
            mdi_s2 <= mdi_s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_PRE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bit_ev) begin
            unique case (state)
                S_PRE:  if (!rx_bit && ones_cnt == PRE_MAX) state_nxt = S_ST;
                S_ST:   state_nxt = rx_bit ? S_OP : S_PRE;
                S_OP:   if (bit_cnt == 4'd1) state_nxt = (op_hi != rx_bit) ? S_PHY : S_PRE;
                S_PHY:  if (bit_cnt == 4'd4) state_nxt = S_REG;
                S_REG:  if (bit_cnt == 4'd4) state_nxt = (phy_r == PHYAD) ? S_TA : S_PRE;
                S_TA:   if (bit_cnt == 4'd1) state_nxt = S_DATA;
                S_DATA: if (bit_cnt == 4'd15) state_nxt = S_PRE;
                default: state_nxt = S_PRE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones_cnt <= '0;
            bit_cnt  <= '0;
            op_hi    <= 1'b0;
            rd_frame <= 1'b0;
            phy_r    <= '0;
            reg_r    <= '0;
            rx_sr    <= '0;
            tx_sr    <= '0;
            cyc_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_live  <= 1'b0;
            rd_ok    <= 1'b0;
            cap      <= 1'b0;
            mdo      <= 1'b0;
            mdo_en   <= 1'b0;
        end else begin
            cap <= 1'b0;
            if (cap) tx_sr <= wb.data_read;
            // rd_live marks a cycle still owned by the current read; once TA
            // passes, a late termination is left to finish but is ignored.
            if (cyc_q && (wb.ack || wb.err)) begin
                cyc_q <= 1'b0;
                if (rd_live) begin
                    rd_live <= 1'b0;
                    if (!wb.err) begin
                        rd_ok <= 1'b1;
                        cap   <= 1'b1;
                    end
                end
            end

            if (bit_ev) begin
                bit_cnt <= (state_nxt != state) ? '0 : bit_cnt + 4'd1;
                unique case (state)
                    S_PRE: begin
                        if (!rx_bit)                 ones_cnt <= '0;
                        else if (ones_cnt != PRE_MAX) ones_cnt <= ones_cnt + 6'd1;
                    end
                    S_OP: begin
                        op_hi    <= rx_bit;
                        rd_frame <= op_hi & ~rx_bit;
                    end
                    S_PHY: phy_r <= {phy_r[3:0], rx_bit};
                    S_REG: begin
                        reg_r <= {reg_r[3:0], rx_bit};
                        if (bit_cnt == 4'd4 && phy_r == PHYAD && rd_frame) begin
                            rd_ok <= 1'b0;
                            if (!cyc_q) begin
                                cyc_q   <= 1'b1;
                                we_q    <= 1'b0;
                                addr_q  <= {reg_r[3:0], rx_bit};
                                rd_live <= 1'b1;
                            end
                        end
                    end
                    S_TA: begin
                        if (bit_cnt == 4'd0) begin
                            rd_live <= 1'b0;
                            if (rd_frame && rd_ok) begin
                                mdo_en <= 1'b1;
                                mdo    <= 1'b0;
                            end
                        end else if (mdo_en) begin
                            mdo   <= tx_sr[15];
                            tx_sr <= {tx_sr[14:0], 1'b0};
                        end
                    end
                    S_DATA: begin
                        rx_sr <= {rx_sr[13:0], rx_bit};
                        if (mdo_en) begin
                            if (bit_cnt == 4'd15) begin
                                mdo_en <= 1'b0;
                                mdo    <= 1'b0;
                            end else begin
                                mdo   <= tx_sr[15];
                                tx_sr <= {tx_sr[14:0], 1'b0};
                            end
                        end
                        if (bit_cnt == 4'd15 && !rd_frame && !cyc_q) begin
                            cyc_q   <= 1'b1;
                            we_q    <= 1'b1;
                            addr_q  <= reg_r;
                            wdata_q <= {rx_sr, rx_bit};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mdio_slave.sv
// Directed bench for mdio_slave: scoreboarded bus cycles and per-bit MDIO output.
module tb_mdio_slave;

    typedef struct {
        logic       we;
        logic [4:0] addr;
        logic [15:0] wdata;
    } bus_t;

    logic clk, rst_n, mdc, mdi, mdo, mdo_en;
    int   checks = 0;
    int   errors = 0;
    bus_t bus_q[$];
    logic [1:0] mdo_q[$];
    logic [15:0] rd_val;
    logic resp_err;

    mdio_slave_if wb();

    mdio_slave #(.PHYAD(5'd1), .PREAMBLE_LEN(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .mdc    (mdc),
        .mdi    (mdi),
        .mdo    (mdo),
        .mdo_en (mdo_en),
        .wb     (wb.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Register-file model: acks (or errs) in the cycle cyc is seen, data follows.
    initial begin
        bus_t e;
        forever begin
            @(negedge clk);
            if (wb.cyc === 1'b1) begin
                chk("stb_eq_cyc", wb.stb, 1);
                if (bus_q.size() == 0) begin
                    chk("unexpected_cyc", 1, 0);
                end else begin
                    e = bus_q.pop_front();
                    chk("bus_we", wb.we, e.we);
                    chk("bus_addr", wb.addr, e.addr);
                    if (e.we) chk("bus_wdata", wb.data_write, e.wdata);
                end
                wb.ack = !resp_err;
                wb.err = resp_err;
                @(negedge clk);
                wb.ack = 1'b0;
                wb.err = 1'b0;
                wb.data_read = rd_val;
                chk("cyc_drop", wb.cyc, 0);
            end
        end
    end

    task automatic clock_bit(input logic b);
        mdi = b;
        #80 mdc = 1'b1;
        #80 mdc = 1'b0;
    endtask

    task automatic send_frame(input int pre_len, input logic [1:0] op, input logic [4:0] phy,
                              input logic [4:0] rega, input logic [15:0] wdata,
                              input bit drive, input logic [15:0] rdata, input int abort_at);
        logic [31:0] fb;
        logic [1:0]  e;
        logic        is_wr;
        is_wr = (op == 2'b01);
        fb = {2'b01, op, phy, rega, is_wr ? 2'b10 : 2'b11, is_wr ? wdata : 16'hFFFF};
        for (int p = 0; p < 32; p++) begin
            if (!drive || p < 15) mdo_q.push_back(2'b00);
            else if (p == 15)     mdo_q.push_back(2'b10);
            else                  mdo_q.push_back({1'b1, rdata[31-p]});
        end
        for (int i = 0; i < pre_len; i++) clock_bit(1'b1);
        for (int p = 0; p < 32; p++) begin
            mdi = fb[31-p];
            #70;
            e = mdo_q.pop_front();
            chk($sformatf("mdo_bit%0d", p), {mdo_en, mdo}, e);
            if (p == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("abort_mdo_en", mdo_en, 0);
                chk("abort_cyc", wb.cyc, 0);
                mdo_q.delete();
                #19 rst_n = 1'b1;
                mdi = 1'b1;
                #10;
                return;
            end
            #10 mdc = 1'b1;
            #80 mdc = 1'b0;
        end
        mdi = 1'b1;
        #80;
        chk("post_frame_mdo", {mdo_en, mdo}, 2'b00);
        #200;
    endtask

    task automatic exp_bus(input logic we, input logic [4:0] a, input logic [15:0] d);
        bus_t e;
        e.we = we;
        e.addr = a;
        e.wdata = d;
        bus_q.push_back(e);
    endtask

    initial begin
        rst_n = 1'b0;
        mdc = 1'b0;
        mdi = 1'b1;
        wb.ack = 1'b0;
        wb.err = 1'b0;
        wb.data_read = '0;
        rd_val = '0;
        resp_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mdo", mdo, 0);
        chk("rst_mdo_en", mdo_en, 0);
        chk("rst_cyc", wb.cyc, 0);
        chk("rst_we", wb.we, 0);
        chk("rst_addr", wb.addr, 0);
        chk("rst_wdata", wb.data_write, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // read register 1
        rd_val = 16'h7809;
        exp_bus(1'b0, 5'd1, '0);
        send_frame(32, 2'b10, 5'd1, 5'd1, '0, 1'b1, 16'h7809, -1);
        chk("rd1_done", bus_q.size(), 0);

        // write register 0
        exp_bus(1'b1, 5'd0, 16'h4000);
        send_frame(32, 2'b01, 5'd1, 5'd0, 16'h4000, 1'b0, '0, -1);
        chk("wr0_done", bus_q.size(), 0);

        // read register 5 terminated with err, then a good read
        resp_err = 1'b1;
        rd_val = 16'hDEAD;
        exp_bus(1'b0, 5'd5, '0);
        send_frame(32, 2'b10, 5'd1, 5'd5, '0, 1'b0, '0, -1);
        resp_err = 1'b0;
        rd_val = 16'hA5C3;
        exp_bus(1'b0, 5'd1, '0);
        send_frame(32, 2'b10, 5'd1, 5'd1, '0, 1'b1, 16'hA5C3, -1);

        // PHY address mismatch, then a matching read
        send_frame(32, 2'b10, 5'd2, 5'd1, '0, 1'b0, '0, -1);
        chk("mismatch_no_cyc", bus_q.size(), 0);
        rd_val = 16'hBEEF;
        exp_bus(1'b0, 5'd3, '0);
        send_frame(32, 2'b10, 5'd1, 5'd3, '0, 1'b1, 16'hBEEF, -1);

        // short preamble ignored, long preamble accepted, OP=11 ignored
        send_frame(31, 2'b10, 5'd1, 5'd1, '0, 1'b0, '0, -1);
        rd_val = 16'h0F0F;
        exp_bus(1'b0, 5'd2, '0);
        send_frame(40, 2'b10, 5'd1, 5'd2, '0, 1'b1, 16'h0F0F, -1);
        send_frame(32, 2'b11, 5'd1, 5'd2, 16'h1234, 1'b0, '0, -1);
        chk("op11_no_cyc", bus_q.size(), 0);

        // reset while data bit 7 is driven, then a clean read
        rd_val = 16'h5A5A;
        exp_bus(1'b0, 5'd1, '0);
        send_frame(32, 2'b10, 5'd1, 5'd1, '0, 1'b1, 16'h5A5A, 24);
        rd_val = 16'hC001;
        exp_bus(1'b0, 5'd4, '0);
        send_frame(32, 2'b10, 5'd1, 5'd4, '0, 1'b1, 16'hC001, -1);

        #500;
        chk("bus_q_empty", bus_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
